hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard controller for the 5-stage pipeline.
- Computes EX-stage operand forwarding from MEM and WB; the WB path is qualified by `regwriteW` and `rdW`.
- Detects load-use hazards and inserts a configurable number of bubbles through a small stall FSM.
- Squashes wrong-path instructions on a taken branch or jump, and freezes the whole pipeline while data memory is busy.
- Keeps saturating stall/flush event counters for performance analysis.

## Interface
Parameters:
- `AW`, 5, register-index width (`2**AW` architectural registers; index 0 is hard-wired zero)
- `LOAD_STALL`, 1, bubbles inserted per load-use hazard (legal range 1..7)
- `CNT_W`, 32, width of the performance counters

Ports:
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-low reset
- `rs1D`, `rs2D` input AW: source registers in decode
- `rs1E`, `rs2E`, `rdE` input AW: sources and destination in execute
- `rdM`, `rdW` input AW: destinations in memory and writeback
- `memreadE` input 1: instruction in EX is a load
- `regwriteM`, `regwriteW` input 1: writeback enables of the MEM and WB instructions
- `pcsrcE` input 1: taken branch or jump resolved in EX
- `dmem_busy` input 1: data memory not ready
- `clr_cnt` input 1: synchronous clear of both counters
- `forwardAE`, `forwardBE` output 2: operand select; 00 register file, 01 WB result, 10 MEM ALU result
- `stallF`, `stallD` output 1: hold PC and IF/ID register
- `freeze` output 1: hold every pipeline register (ID/EX, EX/MEM, MEM/WB included)
- `flushD`, `flushE` output 1: clear IF/ID or ID/EX to a bubble
- `stall_cnt`, `flush_cnt` output CNT_W: event counters

## Operation
Forwarding (combinational, per operand X in {1,2}):
- 10 if `regwriteM` and `rdM != 0` and `rdM == rsXE`.
- Else 01 if `regwriteW` and `rdW != 0` and `rdW == rsXE`.
- Else 00. MEM has priority when both stages match.

Hazard detection:
- Load-use hit (`luh`) = `memreadE` and `rdE != 0` and `rdE` equals `rs1D` or `rs2D`.

FSM states:
- **IDLE**
  - If `luh` and not `pcsrcE`: assert `stallF`, `stallD`, `flushE` this cycle.
  - If `LOAD_STALL > 1`, go to LU_STALL with `cnt = LOAD_STALL-1`.
- **LU_STALL**
  - Assert `stallF`, `stallD`, `flushE`; decrement `cnt`.
  - Return to IDLE in the cycle `cnt == 1` is consumed.

Priority, per cycle:
1. **`dmem_busy`** (highest)
   - `freeze = stallF = stallD = 1`.
   - `flushD = flushE = 0`.
   - FSM state, `cnt` and counters hold.
2. **`pcsrcE`**
   - `flushD = flushE = 1`; stalls deasserted.
   - FSM forced to IDLE, so a pending load-use stall is aborted.
3. **Load-use stall** as described above.

Register file contract:
- With `LOAD_STALL >= 2`, the load reaches or passes WB while the consumer is still in D.
- The register file must be write-first within a cycle.

Counters:
- `stall_cnt` increments each cycle `stallD` is asserted because of load-use (not freeze).
- `flush_cnt` increments each cycle `pcsrcE` is honoured.
- Both saturate at all-ones. `clr_cnt` has priority over increment.

Reset:
- `rst = 0` forces state IDLE, `cnt = 0`, counters 0.
- All outputs read 0, including `forwardAE`/`forwardBE = 00`, independent of inputs.

## Timing
- Forwarding, stall, flush and freeze outputs are combinational from inputs and current state, valid in the same cycle.
- State, `cnt` and counters update on the rising edge.
- Load-use with `LOAD_STALL = N` gives exactly N consecutive cycles of `stallD`, then release in cycle N+1, unless aborted or frozen.
- Freeze cycles during LU_STALL extend the stall; they do not count down.
- Reset deasserting mid-stall: first cycle after release is IDLE.

## Structure
Shared package `hazard_pkg`:
- Forward-select constants `FWD_RF = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`.
- FSM state encoding (IDLE, LU_STALL).

Sub-module `hazard_fwd_sel`:
- Per-operand comparator, instantiated twice.
- Inputs: `rsE`, `rdM`, `rdW`, `regwriteM`, `regwriteW`.
- Output: 2-bit select.

## Test plan
- `rdM = 5`, `regwriteM = 1`, `rs1E = 5`, `rdW = 5`, `regwriteW = 1` → `forwardAE = 10`. Then `regwriteM = 0` → 01. Then `rdW = 0` → 00.
- `regwriteW = 0`, `rdW = rs2E = 7` → `forwardBE = 00`. Checks WB qualification.
- `LOAD_STALL = 3`, `memreadE = 1`, `rdE = rs1D = 4` → `stallF`/`stallD`/`flushE` high for exactly 3 cycles, then low; `stall_cnt = 3`.
- Load-use coincident with `pcsrcE = 1` → `flushD = flushE = 1`, `stallD = 0`, FSM IDLE next cycle, `flush_cnt +1`, `stall_cnt` unchanged.
- `dmem_busy` high 2 cycles during LU_STALL (`LOAD_STALL = 2`) → `freeze = 1`, flushes 0, total `stallD` cycles = 4, `stall_cnt = 2`.
- Counter at all-ones plus another stall → holds. `clr_cnt` → 0. `rst` low mid-LU_STALL → all outputs 0 immediately; first cycle after release is IDLE.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes
// and the load-use stall FSM encoding.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Wide enough for the largest legal bubble count (7).
  localparam int unsigned STALL_CNT_W = 3;

  typedef enum logic {
    StIdle,
    StLuStall
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle. The pipeline drives the
// register indices and status bits; the controller returns the selects and stalls.
interface hazard_ctrl_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
);
  logic [AW-1:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic             memreadE, regwriteM, regwriteW, pcsrcE, dmem_busy, clr_cnt;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, freeze, flushD, flushE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output memreadE, regwriteM, regwriteW, pcsrcE, dmem_busy, clr_cnt,
    input  forwardAE, forwardBE, stallF, stallD, freeze, flushD, flushE,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  memreadE, regwriteM, regwriteW, pcsrcE, dmem_busy, clr_cnt,
    output forwardAE, forwardBE, stallF, stallD, freeze, flushD, flushE,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one EX source register; MEM beats WB and
// register 0 is never forwarded.
module hazard_fwd_sel #(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rdM,
  input  logic [AW-1:0] rdW,
  input  logic          regwriteM,
  input  logic          regwriteW,
  output logic [1:0]    sel
);
  import hazard_pkg::*;

  always_comb begin
    sel = FWD_RF;
    if (regwriteW && (rdW != '0) && (rdW == rsE)) sel = FWD_WB;
    if (regwriteM && (rdM != '0) && (rdM == rsE)) sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX forwarding, load-use bubble insertion, branch squash,
// dmem freeze and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned AW         = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  import hazard_pkg::*;

  hz_state_e              r_state, w_state_nxt;
  logic [STALL_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]       r_stall_cnt, r_flush_cnt;
  logic [1:0]             w_fwd_a, w_fwd_b;
  logic                   w_luh, w_stall_ev, w_flush_ev;
  logic                   w_stall, w_freeze, w_flush_d, w_flush_e;

  hazard_fwd_sel #(.AW(AW)) u_fwd_a (
    .rsE       (bus.rs1E),
    .rdM       (bus.rdM),
    .rdW       (bus.rdW),
    .regwriteM (bus.regwriteM),
    .regwriteW (bus.regwriteW),
    .sel       (w_fwd_a)
  );

  hazard_fwd_sel #(.AW(AW)) u_fwd_b (
    .rsE       (bus.rs2E),
    .rdM       (bus.rdM),
    .rdW       (bus.rdW),
    .regwriteM (bus.regwriteM),
    .regwriteW (bus.regwriteW),
    .sel       (w_fwd_b)
  );

  assign w_luh = bus.memreadE && (bus.rdE != '0) &&
                 ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_freeze    = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_stall_ev  = 1'b0;
    w_flush_ev  = 1'b0;
    if (bus.dmem_busy) begin
      // Everything holds, including the bubble countdown.
      w_freeze = 1'b1;
      w_stall  = 1'b1;
    end else if (bus.pcsrcE) begin
      w_flush_d   = 1'b1;
      w_flush_e   = 1'b1;
      w_flush_ev  = 1'b1;
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
    end else if (r_state == StLuStall) begin
      w_stall    = 1'b1;
      w_flush_e  = 1'b1;
      w_stall_ev = 1'b1;
      w_cnt_nxt  = r_cnt - 1'b1;
      if (r_cnt == STALL_CNT_W'(1)) w_state_nxt = StIdle;
    end else if (w_luh) begin
      w_stall    = 1'b1;
      w_flush_e  = 1'b1;
      w_stall_ev = 1'b1;
      if (LOAD_STALL > 1) begin
        w_state_nxt = StLuStall;
        w_cnt_nxt   = STALL_CNT_W'(LOAD_STALL - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (bus.clr_cnt) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (w_stall_ev && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if (w_flush_ev && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  // Combinational outputs are masked so reset reads all-zero regardless of inputs.
  always_comb begin
    bus.forwardAE = rst ? w_fwd_a : FWD_RF;
    bus.forwardBE = rst ? w_fwd_b : FWD_RF;
    bus.stallF    = rst & w_stall;
    bus.stallD    = rst & w_stall;
    bus.freeze    = rst & w_freeze;
    bus.flushD    = rst & w_flush_d;
    bus.flushE    = rst & w_flush_e;
    bus.stall_cnt = r_stall_cnt;
    bus.flush_cnt = r_flush_cnt;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_STALL 3 and 2) with
// 4-bit counters so saturation is reachable.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf;
    logic       sd;
    logic       fz;
    logic       fd;
    logic       fe;
    logic [3:0] sc;
    logic [3:0] fc;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       memreadE, regwriteM, regwriteW, pcsrcE, dmem_busy, clr_cnt;

  int   n_chk  = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  obs_t want;
  obs_t got_a, got_b;

  hazard_ctrl_if #(.AW(5), .CNT_W(4)) bus_a ();
  hazard_ctrl_if #(.AW(5), .CNT_W(4)) bus_b ();

  hazard_ctrl #(.AW(5), .LOAD_STALL(3), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_a.slave)
  );

  hazard_ctrl #(.AW(5), .LOAD_STALL(2), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_b.slave)
  );

  assign bus_a.rs1D = rs1D;  assign bus_b.rs1D = rs1D;
  assign bus_a.rs2D = rs2D;  assign bus_b.rs2D = rs2D;
  assign bus_a.rs1E = rs1E;  assign bus_b.rs1E = rs1E;
  assign bus_a.rs2E = rs2E;  assign bus_b.rs2E = rs2E;
  assign bus_a.rdE  = rdE;   assign bus_b.rdE  = rdE;
  assign bus_a.rdM  = rdM;   assign bus_b.rdM  = rdM;
  assign bus_a.rdW  = rdW;   assign bus_b.rdW  = rdW;
  assign bus_a.memreadE  = memreadE;   assign bus_b.memreadE  = memreadE;
  assign bus_a.regwriteM = regwriteM;  assign bus_b.regwriteM = regwriteM;
  assign bus_a.regwriteW = regwriteW;  assign bus_b.regwriteW = regwriteW;
  assign bus_a.pcsrcE    = pcsrcE;     assign bus_b.pcsrcE    = pcsrcE;
  assign bus_a.dmem_busy = dmem_busy;  assign bus_b.dmem_busy = dmem_busy;
  assign bus_a.clr_cnt   = clr_cnt;    assign bus_b.clr_cnt   = clr_cnt;

  assign got_a = {bus_a.forwardAE, bus_a.forwardBE, bus_a.stallF, bus_a.stallD, bus_a.freeze,
                  bus_a.flushD, bus_a.flushE, bus_a.stall_cnt, bus_a.flush_cnt};
  assign got_b = {bus_b.forwardAE, bus_b.forwardBE, bus_b.stallF, bus_b.stallD, bus_b.freeze,
                  bus_b.flushD, bus_b.flushE, bus_b.stall_cnt, bus_b.flush_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(logic [1:0] fa, logic [1:0] fb, logic sf, logic sd, logic fz,
                              logic fd, logic fe, logic [3:0] sc, logic [3:0] fc);
    mk = {fa, fb, sf, sd, fz, fd, fe, sc, fc};
  endfunction

  function automatic obs_t idle(logic [3:0] sc, logic [3:0] fc);
    idle = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sc, fc);
  endfunction

  function automatic obs_t stall(logic [3:0] sc, logic [3:0] fc);
    stall = mk(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, sc, fc);
  endfunction

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    memreadE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    pcsrcE = 1'b0; dmem_busy = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic hostile_inputs();
    rdM = 5'd3; rs1E = 5'd3; regwriteM = 1'b1; rdW = 5'd6; rs2E = 5'd6; regwriteW = 1'b1;
    memreadE = 1'b1; rdE = 5'd4; rs1D = 5'd4; pcsrcE = 1'b1; dmem_busy = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    hostile_inputs();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) @(negedge clk);
      exp_q.push_back(idle(4'd0, 4'd0));
      want = exp_q.pop_front();
      n_chk++;
      if ((i % 2 == 0 ? got_a : got_b) !== want) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, (i % 2 == 0 ? got_a : got_b), want);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin
          rdM = 5'd5; regwriteM = 1'b1; rs1E = 5'd5; rdW = 5'd5; regwriteW = 1'b1;
          exp_q.push_back(mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 4'd0, 4'd0));
        end
        1: begin
          regwriteM = 1'b0;
          exp_q.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 4'd0, 4'd0));
        end
        2: begin
          rdW = 5'd0;
          exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 4'd0, 4'd0));
        end
        3: begin
          regwriteW = 1'b0; rdW = 5'd7; rs2E = 5'd7;
          exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 4'd0, 4'd0));
        end
        4: begin
          regwriteW = 1'b1;
          exp_q.push_back(mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 4'd0, 4'd0));
        end
        5: begin
          regwriteM = 1'b1; rdM = 5'd7;
          exp_q.push_back(mk(2'b00, 2'b10, 0, 0, 0, 0, 0, 4'd0, 4'd0));
        end
        default: begin
          rdM = 5'd0; rdW = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
          exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 4'd0, 4'd0));
        end
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got_a !== want) begin
        n_fail++;
        $display("FAIL forwarding[%0d]: got %h expected %h", i, got_a, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    rdE = 5'd4; rs1D = 5'd4;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin memreadE = 1'b1; exp_q.push_back(stall(4'd0, 4'd0)); end
        1: begin memreadE = 1'b0; exp_q.push_back(stall(4'd1, 4'd0)); end
        2: exp_q.push_back(stall(4'd2, 4'd0));
        3: exp_q.push_back(idle(4'd3, 4'd0));
        4: exp_q.push_back(idle(4'd3, 4'd0));
        5: begin
          memreadE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
          exp_q.push_back(idle(4'd3, 4'd0));
        end
        default: begin
          rdE = 5'd9; rs1D = 5'd1; rs2D = 5'd9;
          exp_q.push_back(stall(4'd3, 4'd0));
        end
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got_a !== want) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %h expected %h", i, got_a, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_abort();
    do_reset();
    rdE = 5'd4; rs1D = 5'd4;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin
          memreadE = 1'b1; pcsrcE = 1'b1;
          exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 4'd0, 4'd0));
        end
        1: begin
          memreadE = 1'b0; pcsrcE = 1'b0;
          exp_q.push_back(idle(4'd0, 4'd1));
        end
        2: begin memreadE = 1'b1; exp_q.push_back(stall(4'd0, 4'd1)); end
        3: begin
          memreadE = 1'b0; pcsrcE = 1'b1;
          exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 4'd1, 4'd1));
        end
        default: begin pcsrcE = 1'b0; exp_q.push_back(idle(4'd1, 4'd2)); end
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got_a !== want) begin
        n_fail++;
        $display("FAIL branch_abort[%0d]: got %h expected %h", i, got_a, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze();
    do_reset();
    rdE = 5'd4; rs2D = 5'd4;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin memreadE = 1'b1; exp_q.push_back(stall(4'd0, 4'd0)); end
        1: begin
          memreadE = 1'b0; dmem_busy = 1'b1;
          exp_q.push_back(mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 4'd1, 4'd0));
        end
        2: exp_q.push_back(mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 4'd1, 4'd0));
        3: begin dmem_busy = 1'b0; exp_q.push_back(stall(4'd1, 4'd0)); end
        4: exp_q.push_back(idle(4'd2, 4'd0));
        5: begin
          dmem_busy = 1'b1; pcsrcE = 1'b1;
          exp_q.push_back(mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 4'd2, 4'd0));
        end
        6: begin
          dmem_busy = 1'b0;
          exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 4'd2, 4'd0));
        end
        default: begin pcsrcE = 1'b0; exp_q.push_back(idle(4'd2, 4'd1)); end
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got_b !== want) begin
        n_fail++;
        $display("FAIL freeze[%0d]: got %h expected %h", i, got_b, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    rdE = 5'd4; rs1D = 5'd4;
    // Six load-use events of three bubbles each push stall_cnt past 15.
    for (int i = 0; i < 18; i++) begin
      memreadE = (i % 3 == 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin memreadE = 1'b0; exp_q.push_back(idle(4'd15, 4'd0)); end
        1: begin memreadE = 1'b1; clr_cnt = 1'b1; exp_q.push_back(stall(4'd15, 4'd0)); end
        2: begin memreadE = 1'b0; clr_cnt = 1'b0; exp_q.push_back(stall(4'd0, 4'd0)); end
        3: exp_q.push_back(stall(4'd1, 4'd0));
        default: exp_q.push_back(idle(4'd2, 4'd0));
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got_a !== want) begin
        n_fail++;
        $display("FAIL saturate_clear[%0d]: got %h expected %h", i, got_a, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    rdE = 5'd4; rs1D = 5'd4;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin memreadE = 1'b1; exp_q.push_back(stall(4'd0, 4'd0)); end
        1: begin memreadE = 1'b0; exp_q.push_back(stall(4'd1, 4'd0)); end
        2: begin
          hostile_inputs();
          rst_n = 1'b0;
          #1;
          exp_q.push_back(idle(4'd0, 4'd0));
        end
        3: exp_q.push_back(idle(4'd0, 4'd0));
        default: begin
          clear_inputs();
          rdE = 5'd4; rs1D = 5'd4;
          rst_n = 1'b1;
          exp_q.push_back(idle(4'd0, 4'd0));
        end
      endcase
      if (i != 2) @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got_a !== want) begin
        n_fail++;
        $display("FAIL reset_mid_stall[%0d]: got %h expected %h", i, got_a, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_abort();
    test_freeze();
    test_saturate_clear();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
